// File: rtl/seg7_mux_decoder.sv
// Receive-side decoder for the two-digit multiplexed 7-segment bus: synchronizes and
// debounces {dig, seg}, decodes ones/tens back to BCD and reports the value 0..99.
module seg7_mux_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 81_000
) (
  input  logic       i_clk,
  input  logic       w_rst,
  input  logic [7:0] i_seg,
  input  logic [3:0] i_dig,
  output logic [3:0] o_ones,
  output logic [3:0] o_tens,
  output logic [6:0] o_value,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_err,
  output logic       o_stale
);

  localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam int STALE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   CNT_ACC   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT);

  localparam logic [3:0] DIG_ONES = 4'b1110;
  localparam logic [3:0] DIG_TENS = 4'b1101;
  localparam logic [3:0] DIG_RST  = 4'b1100;
  localparam logic [3:0] DIG_IDLE = 4'b1111;

  // Returns {legal, digit}; segment order is a..g, MSB first.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] dec;
    dec = 5'b0_0000;
    case (seg)
      7'b1111110: dec = {1'b1, 4'd0};
      7'b0110000: dec = {1'b1, 4'd1};
      7'b1101101: dec = {1'b1, 4'd2};
      7'b1111001: dec = {1'b1, 4'd3};
      7'b0110011: dec = {1'b1, 4'd4};
      7'b1011011: dec = {1'b1, 4'd5};
      7'b1011111: dec = {1'b1, 4'd6};
      7'b1110000: dec = {1'b1, 4'd7};
      7'b1111111: dec = {1'b1, 4'd8};
      7'b1111011: dec = {1'b1, 4'd9};
      default:    dec = 5'b0_0000;
    endcase
    return dec;
  endfunction

  function automatic logic [CNT_W-1:0] stab_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  function automatic logic [STALE_W-1:0] stale_sat_inc(input logic [STALE_W-1:0] cnt);
    return (cnt == STALE_MAX) ? cnt : cnt + STALE_W'(1);
  endfunction

  logic [11:0]        r_sync_p0;
  logic [11:0]        r_sync_p1;
  logic [11:0]        r_prev_p2;
  logic               r_sv_p0;
  logic               r_sv_p1;
  logic               r_sv_p2;
  logic [CNT_W-1:0]   r_stab_cnt;
  logic               r_have_ones;
  logic               r_have_tens;
  logic               r_both_seen;
  logic               r_dacc_p3;
  logic [STALE_W-1:0] r_stale_cnt;

  logic       w_same;
  logic       w_accept;
  logic [3:0] w_dig;
  logic [4:0] w_dec;
  logic       w_legal;
  logic [3:0] w_digit;
  logic       w_is_ones;
  logic       w_is_tens;
  logic       w_is_rst;
  logic       w_is_idle;
  logic       w_acc_ones;
  logic       w_acc_tens;
  logic       w_acc_bad;
  logic       w_acc_blank;
  logic       w_acc_slot;
  logic [6:0] w_sum;

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized word.
  // The r_sv_* chain keeps reset-cleared flops from counting as a real stable run.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_prev_p2 <= '0;
      r_sv_p0   <= 1'b0;
      r_sv_p1   <= 1'b0;
      r_sv_p2   <= 1'b0;
    end else begin
      r_sync_p0 <= {i_dig, i_seg};
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
      r_sv_p0   <= 1'b1;
      r_sv_p1   <= r_sv_p0;
      r_sv_p2   <= r_sv_p1;
    end
  end

  assign w_same   = r_sv_p2 && (r_sync_p1 == r_prev_p2);
  assign w_accept = w_same && (r_stab_cnt == CNT_ACC);

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_stab_cnt <= '0;
    end else if (!w_same) begin
      r_stab_cnt <= '0;
    end else begin
      r_stab_cnt <= stab_sat_inc(r_stab_cnt);
    end
  end

  assign w_dig     = r_sync_p1[11:8];
  assign w_dec     = seg_decode(r_sync_p1[7:1]);
  assign w_legal   = w_dec[4];
  assign w_digit   = w_dec[3:0];
  assign w_is_ones = (w_dig == DIG_ONES);
  assign w_is_tens = (w_dig == DIG_TENS);
  assign w_is_rst  = (w_dig == DIG_RST);
  assign w_is_idle = (w_dig == DIG_IDLE);

  assign w_acc_ones  = w_accept && w_is_ones && w_legal;
  assign w_acc_tens  = w_accept && w_is_tens && w_legal;
  assign w_acc_blank = w_accept && w_is_rst;
  assign w_acc_slot  = w_accept && (w_is_ones || w_is_tens);
  assign w_acc_bad   = w_accept &&
                       (((w_is_ones || w_is_tens) && !w_legal) ||
                        !(w_is_ones || w_is_tens || w_is_rst || w_is_idle));

  // Stage p3: accept actions on digit registers and status flags.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      o_ones      <= '0;
      o_tens      <= '0;
      r_have_ones <= 1'b0;
      r_have_tens <= 1'b0;
      o_blank     <= 1'b0;
      o_err       <= 1'b0;
      r_dacc_p3   <= 1'b0;
    end else begin
      r_dacc_p3 <= w_acc_ones || w_acc_tens;
      if (w_acc_ones) begin
        o_ones      <= w_digit;
        r_have_ones <= 1'b1;
        o_blank     <= 1'b0;
      end
      if (w_acc_tens) begin
        o_tens      <= w_digit;
        r_have_tens <= 1'b1;
        o_blank     <= 1'b0;
      end
      if (w_acc_bad) begin
        o_err <= 1'b1;
      end
      if (w_acc_blank) begin
        o_ones      <= '0;
        o_tens      <= '0;
        r_have_ones <= 1'b0;
        r_have_tens <= 1'b0;
        o_blank     <= 1'b1;
      end
    end
  end

  // Stage p4: tens*10 + ones as (t<<3) + (t<<1) + ones; digits are <= 9 so 7 bits suffice.
  assign w_sum = {o_tens, 3'b000} + {2'b00, o_tens, 1'b0} + {3'b000, o_ones};

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      o_value     <= '0;
      o_valid     <= 1'b0;
      r_both_seen <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (w_acc_blank) begin
        o_value     <= '0;
        r_both_seen <= 1'b0;
      end else if (r_dacc_p3 && r_have_ones && r_have_tens &&
                   ((w_sum != o_value) || !r_both_seen)) begin
        o_value     <= w_sum;
        o_valid     <= 1'b1;
        r_both_seen <= 1'b1;
      end
    end
  end

  // Idle (1111) accepts deliberately do not count as scan activity.
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_stale_cnt <= '0;
    end else if (w_acc_slot || w_acc_blank) begin
      r_stale_cnt <= '0;
    end else begin
      r_stale_cnt <= stale_sat_inc(r_stale_cnt);
    end
  end

  assign o_stale = (r_stale_cnt == STALE_MAX);

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder: digit capture, glitch rejection, illegal and
// blank patterns, stale scan, and a 0..99 sweep with an asynchronous reset in the middle.
module tb_seg7_mux_decoder;

  localparam int SC = 4;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg;
  logic [3:0] dig;
  logic [3:0] o_ones;
  logic [3:0] o_tens;
  logic [6:0] o_value;
  logic       o_valid;
  logic       o_blank;
  logic       o_err;
  logic       o_stale;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v0;
  int d;

  seg7_mux_decoder #(
    .STABLE_CYCLES(SC),
    .TIMEOUT      (TO)
  ) dut (
    .i_clk  (clk),
    .w_rst  (rst),
    .i_seg  (seg),
    .i_dig  (dig),
    .o_ones (o_ones),
    .o_tens (o_tens),
    .o_value(o_value),
    .o_valid(o_valid),
    .o_blank(o_blank),
    .o_err  (o_err),
    .o_stale(o_stale)
  );

  always #5 clk = ~clk;

  // Strobe counter sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (o_valid === 1'b1) vcount++;
  end

  function automatic logic [7:0] enc(input int digit);
    logic [6:0] p;
    case (digit)
      0: p = 7'b1111110;
      1: p = 7'b0110000;
      2: p = 7'b1101101;
      3: p = 7'b1111001;
      4: p = 7'b0110011;
      5: p = 7'b1011011;
      6: p = 7'b1011111;
      7: p = 7'b1110000;
      8: p = 7'b1111111;
      default: p = 7'b1111011;
    endcase
    return {p, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] dg, input logic [7:0] sg);
    dig = dg;
    seg = sg;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b1111, 8'h00);
    tick(3);
    chk("reset_outputs", {o_ones, o_tens, o_value, o_valid, o_blank, o_err, o_stale}, 0);
    rst = 1'b0;
    tick(10);

    // Ones then tens capture; value 21 strobes 7 edges after the tens change.
    drive(4'b1110, 8'h60);
    tick(10);
    chk("t1_ones", o_ones, 1);
    v0 = vcount;
    drive(4'b1101, 8'hDA);
    tick(7);
    chk("t1_valid_early", o_valid, 0);
    tick(1);
    chk("t1_valid_n7", o_valid, 1);
    chk("t1_value", o_value, 21);
    tick(1);
    chk("t1_valid_one_cycle", o_valid, 0);
    tick(1);
    chk("t1_tens", o_tens, 2);
    chk("t1_valid_count", vcount - v0, 1);

    // Four-sample glitch is rejected; re-accepting the same ones digit gives no strobe.
    v0 = vcount;
    drive(4'b1110, 8'hB6);
    tick(4);
    drive(4'b1110, 8'h60);
    tick(12);
    chk("t2_ones_kept", o_ones, 1);
    chk("t2_value_kept", o_value, 21);
    chk("t2_no_valid", vcount - v0, 0);

    // Illegal segment pattern sets the sticky error at N+6; dp bit is ignored afterwards.
    drive(4'b1110, 8'h00);
    tick(6);
    chk("t3_err_early", o_err, 0);
    tick(1);
    chk("t3_err_n6", o_err, 1);
    chk("t3_ones_unchanged", o_ones, 1);
    drive(4'b1110, 8'h61);
    tick(10);
    chk("t3_err_sticky", o_err, 1);
    chk("t3_ones_dp", o_ones, 1);

    // Source-reset pattern blanks the display, then 43 is rebuilt.
    v0 = vcount;
    drive(4'b1100, 8'h00);
    tick(10);
    chk("t4_blank", o_blank, 1);
    chk("t4_value_zero", o_value, 0);
    chk("t4_digits_zero", {o_ones, o_tens}, 0);
    chk("t4_blank_no_valid", vcount - v0, 0);
    drive(4'b1110, enc(3));
    tick(10);
    chk("t4_blank_cleared", o_blank, 0);
    chk("t4_ones3", o_ones, 3);
    drive(4'b1101, enc(4));
    tick(10);
    chk("t4_value43", o_value, 43);
    chk("t4_valid_count", vcount - v0, 1);

    // Frozen idle bus: stale rises TO edges after the tens accept at N+6.
    drive(4'b1111, 8'h00);
    tick(TO - 4);
    chk("t5_stale_early", o_stale, 0);
    tick(1);
    chk("t5_stale_rise", o_stale, 1);
    v0 = vcount;
    drive(4'b1110, enc(3));
    tick(6);
    chk("t5_stale_held", o_stale, 1);
    tick(1);
    chk("t5_stale_clear", o_stale, 0);
    tick(5);
    chk("t5_no_valid", vcount - v0, 0);

    // Full sweep driven like the display counter, with an async reset at 51.
    rst = 1'b1;
    drive(4'b1111, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(5);
    for (int v = 0; v <= 100; v++) begin
      d = v % 100;
      drive(4'b1110, enc(d % 10));
      if (v == 51) begin
        tick(3);
        #2 rst = 1'b1;
        #1 chk("sw_rst_async", {o_ones, o_tens, o_value, o_valid, o_blank, o_err, o_stale}, 0);
        tick(2);
        chk("sw_rst_held", {o_ones, o_tens, o_value, o_valid, o_blank, o_err, o_stale}, 0);
        v0 = vcount;
        rst = 1'b0;
        tick(12);
        chk("sw_release_no_valid", vcount - v0, 0);
        chk("sw_release_value", o_value, 0);
        chk("sw_release_ones", o_ones, 1);
      end else begin
        tick(8);
      end
      drive(4'b1101, enc(d / 10));
      tick(8);
      chk($sformatf("sweep_%0d", v), o_value, d);
    end
    chk("sweep_no_err", o_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
